// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/exception controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [31:0] ERET_CODE  = 32'h0000_000e;
    localparam logic [31:0] EXC_OFFSET = 32'h0000_0180;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EXE = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int W = 32,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: reset and clear win over increment, saturate at MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != MAX)) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: cumulative stall vector, flush pulse
// with PC redirect, saturating debug counters and a sticky stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = 6,
    parameter int XLEN = 32,
    parameter int FLUSH_HOLD = 1,
    parameter int STALL_MAX = 1024,
    parameter int CNT_W = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              exc_valid,
    input  logic [XLEN-1:0]   exc_type,
    input  logic [XLEN-1:0]   cp0_epc,
    input  logic [XLEN-1:0]   cp0_ebase,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              stall_timeout
);

    localparam int HW  = $clog2(FLUSH_HOLD + 1);
    localparam int WDW = $clog2(STALL_MAX + 1);

    state_t            state_r, next_state_s;
    logic [HW-1:0]     hold_r, hold_next_s;
    logic [NSTAGE-1:0] thermo_s, stall_s;
    logic              flush_s, redirect_valid_s, accept_s, stall_any_s;
    logic [XLEN-1:0]   redirect_pc_s;
    logic [WDW-1:0]    wd_count_s;
    logic              timeout_r;

    // Highest requesting stage stalls itself and every stage behind it.
    always_comb begin
        logic acc_v;
        acc_v    = 1'b0;
        thermo_s = {NSTAGE{1'b0}};
        for (int i = NSTAGE - 1; i >= STG_PC; i--) begin
            acc_v       = acc_v | stall_req[i];
            thermo_s[i] = acc_v;
        end
    end

    // Next-state and output decode; reset masks every output.
    always_comb begin
        next_state_s     = state_r;
        hold_next_s      = hold_r;
        stall_s          = {NSTAGE{1'b0}};
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = RESET_VEC;
        accept_s         = 1'b0;
        if (rst) begin
            next_state_s = RUN;
            hold_next_s  = {HW{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (exc_valid) begin
                        accept_s         = 1'b1;
                        flush_s          = 1'b1;
                        redirect_valid_s = 1'b1;
                        if (exc_type == XLEN'(ERET_CODE)) begin
                            redirect_pc_s = cp0_epc;
                        end else begin
                            redirect_pc_s = cp0_ebase + XLEN'(EXC_OFFSET);
                        end
                        if (FLUSH_HOLD > 1) begin
                            next_state_s = FLUSH;
                            hold_next_s  = HW'(FLUSH_HOLD - 1);
                        end else begin
                            next_state_s = RUN;
                        end
                    end else begin
                        stall_s = thermo_s;
                    end
                end
                FLUSH: begin
                    flush_s     = 1'b1;
                    hold_next_s = hold_r - HW'(1'b1);
                    if (hold_r == HW'(1'b1)) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = FLUSH;
                    end
                end
                default: begin
                    next_state_s = RUN;
                    hold_next_s  = {HW{1'b0}};
                end
            endcase
        end
    end

    // State and flush-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            hold_r  <= {HW{1'b0}};
        end else begin
            state_r <= next_state_s;
            hold_r  <= hold_next_s;
        end
    end

    assign stall_any_s = |stall_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(stall_any_s), .count(stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(accept_s), .count(flush_count)
    );

    // Run-length of consecutive stalled cycles; any free cycle restarts it.
    sat_counter #(.W(WDW), .MAX(WDW'(STALL_MAX))) u_wd_cnt (
        .clk(clk), .rst(rst), .clr(~stall_any_s), .inc(stall_any_s), .count(wd_count_s)
    );

    // Sticky timeout sets on the same edge the run counter reaches STALL_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else if (stall_any_s && (wd_count_s >= WDW'(STALL_MAX - 1))) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign stall          = stall_s;
    assign flush          = flush_s;
    assign redirect_valid = redirect_valid_s;
    assign redirect_pc    = redirect_pc_s;
    assign stall_timeout  = timeout_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with FLUSH_HOLD=3, STALL_MAX=4, CNT_W=4.
module tb_pipe_ctrl;

    localparam logic [31:0] RV = 32'h8000_0000;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  sreq;
        logic        ev;
        logic [31:0] et;
        logic [31:0] epc;
        logic [31:0] eb;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall_req = 6'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_type = 32'h0;
    logic [31:0] cp0_epc = 32'h0;
    logic [31:0] cp0_ebase = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  stall_cycles;
    logic [3:0]  flush_count;
    logic        stall_timeout;

    int n_checks = 0;
    int n_errors = 0;
    vec_t sb_q[$];
    vec_t tbl[$];

    pipe_ctrl #(
        .NSTAGE(6), .XLEN(32), .FLUSH_HOLD(3), .STALL_MAX(4), .CNT_W(4),
        .RESET_VEC(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .exc_valid(exc_valid),
        .exc_type(exc_type), .cp0_epc(cp0_epc), .cp0_ebase(cp0_ebase),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic r, logic [5:0] sr, logic ev,
                                logic [31:0] et, logic [31:0] epc, logic [31:0] eb,
                                logic [5:0] es, logic ef, logic erv, logic [31:0] erpc);
        vec_t v;
        v.name = n; v.rst = r; v.sreq = sr; v.ev = ev; v.et = et; v.epc = epc; v.eb = eb;
        v.e_stall = es; v.e_flush = ef; v.e_rv = erv; v.e_rpc = erpc;
        return v;
    endfunction

    // Pop the oldest expectation and compare against the combinational outputs.
    task automatic check_out();
        vec_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: queue empty, required one pending expectation");
        end else begin
            e = sb_q.pop_front();
            if (stall !== e.e_stall || flush !== e.e_flush ||
                redirect_valid !== e.e_rv || redirect_pc !== e.e_rpc) begin
                n_errors++;
                $display("FAIL %s: got stall=%b flush=%b rv=%b pc=%h, required stall=%b flush=%b rv=%b pc=%h",
                         e.name, stall, flush, redirect_valid, redirect_pc,
                         e.e_stall, e.e_flush, e.e_rv, e.e_rpc);
            end
        end
    endtask

    // Drive one cycle of stimulus, record its expectation, sample mid-cycle.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.rst; stall_req = v.sreq; exc_valid = v.ev;
        exc_type = v.et; cp0_epc = v.epc; cp0_ebase = v.eb;
        sb_q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", n, got, exp);
        end
    endtask

    task automatic idle(input string n);
        step(mk(n, 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b0, 1'b0, RV));
    endtask

    initial begin
        // Combinational stall encoding vectors, run from RUN state.
        tbl.push_back(mk("stall_010100", 1'b0, 6'b010100, 1'b0, 32'h0, 32'h0, 32'h0, 6'b011111, 1'b0, 1'b0, RV));
        tbl.push_back(mk("stall_000010", 1'b0, 6'b000010, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000011, 1'b0, 1'b0, RV));
        tbl.push_back(mk("stall_none",   1'b0, 6'b000000, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 1'b0, RV));
        tbl.push_back(mk("stall_100000", 1'b0, 6'b100000, 1'b0, 32'h0, 32'h0, 32'h0, 6'b111111, 1'b0, 1'b0, RV));
        tbl.push_back(mk("stall_000001", 1'b0, 6'b000001, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000001, 1'b0, 1'b0, RV));

        step(mk("reset_a", 1'b1, 6'b111111, 1'b1, 32'h8, 32'h0, 32'h1000, 6'b0, 1'b0, 1'b0, RV));
        step(mk("reset_b", 1'b1, 6'b111111, 1'b1, 32'h8, 32'h0, 32'h1000, 6'b0, 1'b0, 1'b0, RV));
        chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset_flush_count", 32'(flush_count), 32'd0);
        chk("reset_timeout", 32'(stall_timeout), 32'd0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        idle("idle_a");
        chk("stall_cycles_after_table", 32'(stall_cycles), 32'd4);
        idle("idle_b");
        chk("stall_cycles_unchanged", 32'(stall_cycles), 32'd4);

        // Exception beats stall; second exception in FLUSH is dropped.
        step(mk("exc_prio", 1'b0, 6'b010000, 1'b1, 32'h8, 32'h0, 32'h8000_1000, 6'b0, 1'b1, 1'b1, 32'h8000_1180));
        step(mk("flush_c2", 1'b0, 6'b111000, 1'b1, 32'h8, 32'h0, 32'h8000_2000, 6'b0, 1'b1, 1'b0, RV));
        step(mk("flush_c3", 1'b0, 6'b000000, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0, RV));
        idle("flush_drop");
        chk("flush_count_one", 32'(flush_count), 32'd1);
        chk("flush_no_stall_count", 32'(stall_cycles), 32'd4);

        // ERET return, then an exception on the first cycle after flush drops.
        step(mk("eret", 1'b0, 6'b0, 1'b1, 32'h0000_000e, 32'h8000_0044, 32'h8000_1000, 6'b0, 1'b1, 1'b1, 32'h8000_0044));
        step(mk("eret_f2", 1'b0, 6'b000001, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0, RV));
        step(mk("eret_f3", 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0, RV));
        step(mk("exc_wrap", 1'b0, 6'b0, 1'b1, 32'h4, 32'h0, 32'hffff_ff00, 6'b0, 1'b1, 1'b1, 32'h0000_0080));
        step(mk("wrap_f2", 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0, RV));
        step(mk("wrap_f3", 1'b0, 6'b0, 1'b0, 32'h0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0, RV));
        idle("wrap_drop");
        chk("flush_count_three", 32'(flush_count), 32'd3);

        // Watchdog: 3 stalled, 1 free, 4 stalled.
        for (int i = 0; i < 3; i++)
            step(mk("wd_a", 1'b0, 6'b000100, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000111, 1'b0, 1'b0, RV));
        idle("wd_free");
        chk("wd_not_after_3", 32'(stall_timeout), 32'd0);
        for (int i = 0; i < 4; i++)
            step(mk("wd_b", 1'b0, 6'b001000, 1'b0, 32'h0, 32'h0, 32'h0, 6'b001111, 1'b0, 1'b0, RV));
        chk("wd_not_during_4th", 32'(stall_timeout), 32'd0);
        idle("wd_end");
        chk("wd_set_after_4th", 32'(stall_timeout), 32'd1);
        chk("stall_cycles_eleven", 32'(stall_cycles), 32'd11);
        idle("wd_hold");
        chk("wd_sticky", 32'(stall_timeout), 32'd1);

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++)
            step(mk("sat", 1'b0, 6'b000001, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000001, 1'b0, 1'b0, RV));
        idle("sat_end");
        chk("stall_cycles_saturated", 32'(stall_cycles), 32'd15);

        // Reset arriving mid-FLUSH.
        step(mk("exc_pre_rst", 1'b0, 6'b0, 1'b1, 32'h8, 32'h0, 32'h0, 6'b0, 1'b1, 1'b1, 32'h0000_0180));
        step(mk("rst_in_flush", 1'b1, 6'b000011, 1'b1, 32'h8, 32'h0, 32'h0, 6'b0, 1'b0, 1'b0, RV));
        chk("flush_count_four", 32'(flush_count), 32'd4);
        step(mk("run_after_rst", 1'b0, 6'b000001, 1'b0, 32'h0, 32'h0, 32'h0, 6'b000001, 1'b0, 1'b0, RV));
        chk("rst_clears_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_clears_flush_count", 32'(flush_count), 32'd0);
        chk("rst_clears_timeout", 32'(stall_timeout), 32'd0);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard and exception controller for the MIPS32 core. It sits beside the pipeline and merges per-stage stall requests into a cumulative stall vector. It converts committed exceptions into a flush pulse of configurable length plus a one-cycle PC redirect. It also keeps saturating stall and flush counters and a stall watchdog for debug.

## Interface
Parameters:
- NSTAGE, 6, number of pipeline stages; index 0 = PC, 1 = IF, 2 = ID, 3 = EXE, 4 = MEM, 5 = WB
- XLEN, 32, address/data width
- FLUSH_HOLD, 1, total cycles flush stays high per accepted exception (≥1)
- STALL_MAX, 1024, consecutive stalled cycles that trip the watchdog
- CNT_W, 32, width of the performance counters
- RESET_VEC, 32'h8000_0000, value driven on redirect_pc when no redirect is active

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_req  in  NSTAGE  bit k = stage k requests a stall
- exc_valid  in  1  committed exception/ERET present this cycle
- exc_type  in  XLEN  exception code; ERET_CODE selects the EPC return
- cp0_epc  in  XLEN  CP0 EPC
- cp0_ebase  in  XLEN  CP0 EBase
- stall  out  NSTAGE  per-stage stall
- flush  out  1  flush all pipeline registers
- redirect_valid  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  XLEN  handler/return address
- stall_cycles  out  CNT_W  cycles with stall != 0
- flush_count  out  CNT_W  accepted exceptions
- stall_timeout  out  1  sticky watchdog flag

## Operation
- FSM states are RUN and FLUSH.
- **RUN, exc_valid=1:** the exception is accepted.
  - Same cycle: flush=1, stall=0, redirect_valid=1.
  - redirect_pc = cp0_epc if exc_type==ERET_CODE; otherwise cp0_ebase+EXC_OFFSET (0x180), wrapping modulo 2^XLEN.
  - flush_count increments.
  - If FLUSH_HOLD>1: load hold counter with FLUSH_HOLD-1 and go to FLUSH.
- **RUN, exc_valid=0:** flush=0, redirect_valid=0, redirect_pc=RESET_VEC.
  - Let k = highest set index of stall_req.
  - stall[k:0]=1 and upper bits=0. Example: request from stage 4 gives stall=6'b011111.
  - No request gives stall=0.
- **FLUSH:** flush=1, stall=0, redirect_valid=0, redirect_pc=RESET_VEC.
  - exc_valid and stall_req are ignored; exceptions arriving here are not queued.
  - The hold counter decrements each cycle.
  - Return to RUN on the cycle after the counter reads 1.
- **Exception priority:** an exception always beats stall requests in the same cycle.
- **Counters:** stall_cycles and flush_count saturate at all-ones and never wrap.
- **Watchdog:**
  - The run counter increments while stall != 0 and clears on any cycle with stall == 0.
  - When it reaches STALL_MAX, stall_timeout sets. It stays set until rst.
  - The run counter saturates at STALL_MAX.
- **Reset:** rst forces state RUN; clears the hold counter, watchdog counter, stall_cycles, flush_count and stall_timeout.
  - While rst=1: stall=0, flush=0, redirect_valid=0, redirect_pc=RESET_VEC.
  - This holds even if rst arrives mid-FLUSH.

## Timing
- Combinational paths, zero latency: stall, flush, redirect_valid and redirect_pc from stall_req/exc_* in RUN.
- Registered: state, hold counter, counters, stall_timeout; all update on the clk edge.
- Flush length is exactly FLUSH_HOLD cycles, the first being the acceptance cycle.
  - The next exception can be accepted on the cycle after flush drops.
  - With FLUSH_HOLD=1 there is no FLUSH state, so back-to-back exceptions are accepted every cycle.
- Counter timing: stall_cycles/flush_count reflect a cycle's event from the following cycle.
- Watchdog timing: stall_timeout rises on the edge ending the STALL_MAX-th consecutive stalled cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, FLUSH}
  - ERET_CODE = 32'h0000_000e
  - EXC_OFFSET = 32'h0000_0180
  - stage index constants (STG_PC..STG_WB)
- One sub-module, sat_counter (parameter W, inputs inc and clr), instantiated for stall_cycles, flush_count and the watchdog run counter.
- Hold counter width is $clog2(FLUSH_HOLD+1).

## Test plan
- Stall encoding: stall_req=6'b010100 → stall=6'b011111; stall_req=6'b000010 → stall=6'b000011; stall_req=0 → stall=0 and stall_cycles unchanged.
- Exception priority: stall_req=6'b010000, exc_valid=1, exc_type=8, cp0_ebase=32'h8000_1000 → stall=0, flush=1, redirect_pc=32'h8000_1180, flush_count increments by 1.
- ERET return: exc_type=32'h0e, cp0_epc=32'h8000_0044 → redirect_pc=32'h8000_0044 for one cycle; flush lasts FLUSH_HOLD cycles.
- Flush hold, FLUSH_HOLD=3: second exc_valid in cycle 2 is ignored, flush high for exactly 3 cycles, redirect_valid high only in cycle 1, flush_count=1.
- Watchdog, STALL_MAX=4: 3 stalled cycles, 1 free, then 4 stalled → stall_timeout rises only after the fourth; it stays set after stalls end and clears only on rst.
- Reset and saturation: rst asserted mid-FLUSH → next cycle flush=0 and state RUN. CNT_W=4 with 20 stalled cycles → stall_cycles=4'hF.
